// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter and transfer sequencer for a single-port synchronous RAM
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter bit RR     = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              MEM_W,
  output logic              MEM_ON,
  output logic [ADDR_W-1:0] MEM_ADDR,
  inout  wire logic [DATA_W-1:0] Mem_Bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_ADDR = 2'd1,
    S_RD_DATA = 2'd2,
    S_WR      = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic                owner_q,  owner_d;
  logic                last_q,   last_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

  logic eff0, eff1;
  logic grant_vld, grant_sel;

  // A port is masked during its own ack cycle so a still-held req is not regranted.
  assign eff0 = p0_req & ~p0_ack_q;
  assign eff1 = p1_req & ~p1_ack_q;

  // In fixed-priority mode port 0 also yields while port 1 merely holds req in
  // its ack cycle, otherwise port 0 would slip in after every port 1 transfer.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (RR) begin
      grant_vld = eff0 | eff1;
      grant_sel = (eff0 & eff1) ? ~last_q : eff1;
    end else begin
      grant_vld = eff1 | (eff0 & ~p1_req);
      grant_sel = eff1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_d    = owner_q;
    last_d     = last_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          addr_d  = grant_sel ? p1_addr  : p0_addr;
          wdata_d = grant_sel ? p1_wdata : p0_wdata;
          owner_d = grant_sel;
          last_d  = grant_sel;
          state_d = (grant_sel ? p1_we : p0_we) ? S_WR : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (owner_q) begin
          p1_rdata_d = Mem_Bus;
          p1_ack_d   = 1'b1;
        end else begin
          p0_rdata_d = Mem_Bus;
          p0_ack_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_WR: begin
        if (owner_q) p1_ack_d = 1'b1;
        else         p0_ack_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign MEM_ON   = (state_q != S_IDLE);
  assign MEM_W    = (state_q == S_WR);
  assign MEM_ADDR = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

  assign Mem_Bus = (state_q == S_WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter in round-robin and fixed-priority builds
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        a_p0_req, a_p0_we, a_p0_ack, a_p1_req, a_p1_we, a_p1_ack;
  logic [15:0] a_p0_addr, a_p0_wdata, a_p0_rdata, a_p1_addr, a_p1_wdata, a_p1_rdata;
  logic        a_mem_w, a_mem_on, a_busy;
  logic [15:0] a_mem_addr;
  wire  [15:0] a_bus;

  logic        b_p0_req, b_p0_we, b_p0_ack, b_p1_req, b_p1_we, b_p1_ack;
  logic [15:0] b_p0_addr, b_p0_wdata, b_p0_rdata, b_p1_addr, b_p1_wdata, b_p1_rdata;
  logic        b_mem_w, b_mem_on, b_busy;
  logic [15:0] b_mem_addr;
  wire  [15:0] b_bus;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR(1'b1)) dut_a (
    .CLK(CLK), .RST(RST),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .MEM_W(a_mem_w), .MEM_ON(a_mem_on), .MEM_ADDR(a_mem_addr), .Mem_Bus(a_bus), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR(1'b0)) dut_b (
    .CLK(CLK), .RST(RST),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .MEM_W(b_mem_w), .MEM_ON(b_mem_on), .MEM_ADDR(b_mem_addr), .Mem_Bus(b_bus), .busy(b_busy)
  );

  // Synchronous RAMs: registered read data driven onto the bus while enabled for read
  logic [15:0] ram_a [0:255];
  logic [15:0] ram_b [0:255];
  logic [15:0] dout_a, dout_b;

  always @(posedge CLK) begin
    if (a_mem_on) begin
      if (a_mem_w) ram_a[a_mem_addr[7:0]] <= a_bus;
      else         dout_a <= ram_a[a_mem_addr[7:0]];
    end
    if (b_mem_on) begin
      if (b_mem_w) ram_b[b_mem_addr[7:0]] <= b_bus;
      else         dout_b <= ram_b[b_mem_addr[7:0]];
    end
  end

  assign a_bus = (a_mem_on && !a_mem_w) ? dout_a : 16'bz;
  assign b_bus = (b_mem_on && !b_mem_w) ? dout_b : 16'bz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive_a(input bit p, input logic r, input logic w,
                         input logic [15:0] ad, input logic [15:0] wd);
    if (p) begin
      a_p1_req = r; a_p1_we = w; a_p1_addr = ad; a_p1_wdata = wd;
    end else begin
      a_p0_req = r; a_p0_we = w; a_p0_addr = ad; a_p0_wdata = wd;
    end
  endtask

  task automatic xfer_a(input bit p, input bit w, input logic [15:0] ad, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat, output int wcyc,
                        output logic [15:0] wbus, output logic [15:0] maddr);
    lat = -1; wcyc = 0; wbus = '0; maddr = '0; rd = '0;
    drive_a(p, 1'b1, w, ad, wd);
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1;
      if (n == 1) maddr = a_mem_addr;
      if (a_mem_w) begin
        wcyc++;
        wbus = a_bus;
      end
      if (p ? a_p1_ack : a_p0_ack) begin
        lat = n;
        rd  = p ? a_p1_rdata : a_p0_rdata;
        break;
      end
    end
    drive_a(p, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t        vt [9];
  logic [15:0] exp_r0, exp_r1, rd, wbus, maddr, val;
  int          lat, wcyc, k, a1, a2, c, p1n, p0at;
  logic        b4;

  // Transaction-level model for the random phase
  logic [15:0] mem_m [16];
  bit          act [2];
  bit          r_we [2];
  logic [15:0] r_addr [2];
  logic [15:0] r_wd [2];
  int          age [2];
  logic [15:0] exp_rd [2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2};
    vt[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};
    vt[2] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 2};
    vt[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3};
    vt[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3};
    vt[5] = '{1'b1, 1'b1, 16'h0020, 16'h5A5A, 16'h0000, 2};
    vt[6] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 3};
    vt[7] = '{1'b0, 1'b1, 16'hFF00, 16'hFFFF, 16'h0000, 2};
    vt[8] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'hFFFF, 3};

    RST = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_a(1, 0, 0, 0, 0);
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = 16'h0003; b_p0_wdata = 0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = 16'h0004; b_p1_wdata = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    chk("reset_mem_on", 32'(a_mem_on), 0);
    chk("reset_mem_w", 32'(a_mem_w), 0);
    chk("reset_mem_addr", 32'(a_mem_addr), 0);
    chk("reset_busy", 32'(a_busy), 0);
    chk("reset_acks", 32'({a_p0_ack, a_p1_ack, b_p0_ack, b_p1_ack}), 0);
    chk("reset_rdata", 32'(a_p0_rdata | a_p1_rdata), 0);
    exp_r0 = 16'h0; exp_r1 = 16'h0;

    for (int i = 0; i < 9; i++) begin
      xfer_a(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, rd, lat, wcyc, wbus, maddr);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_mem_addr", i), 32'(maddr), 32'(vt[i].addr));
      chk($sformatf("vec%0d_write_cycles", i), 32'(wcyc), vt[i].we ? 32'd1 : 32'd0);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_write_bus", i), 32'(wbus), 32'(vt[i].wdata));
      end else begin
        chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rdata));
        if (vt[i].port) exp_r1 = vt[i].exp_rdata;
        else            exp_r0 = vt[i].exp_rdata;
      end
      chk($sformatf("vec%0d_p0_rdata_held", i), 32'(a_p0_rdata), 32'(exp_r0));
      chk($sformatf("vec%0d_p1_rdata_held", i), 32'(a_p1_rdata), 32'(exp_r1));
    end

    // Reset while a read sits in RD_DATA
    drive_a(0, 1, 0, 16'h0010, 16'h0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst_mid_pre_busy", 32'(a_busy), 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_mem_on", 32'(a_mem_on), 0);
    chk("rst_mid_mem_w", 32'(a_mem_w), 0);
    chk("rst_mid_busy", 32'(a_busy), 0);
    chk("rst_mid_mem_addr", 32'(a_mem_addr), 0);
    chk("rst_mid_rdata", 32'(a_p0_rdata | a_p1_rdata), 0);
    exp_r0 = 16'h0; exp_r1 = 16'h0;
    @(posedge CLK); #1;
    chk("rst_mid_no_ack", 32'(a_p0_ack | a_p1_ack), 0);
    RST = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1;
      if (a_p0_ack) begin
        lat = n;
        rd  = a_p0_rdata;
        break;
      end
    end
    drive_a(0, 0, 0, 0, 0);
    chk("rst_reissue_latency", 32'(lat), 3);
    chk("rst_reissue_rdata", 32'(rd), 32'h0000BEEF);
    exp_r0 = 16'hBEEF;
    @(posedge CLK); #1;

    // Round-robin contention; port 0 was served last so port 1 leads
    drive_a(0, 1, 0, 16'h0020, 16'h0);
    drive_a(1, 1, 0, 16'h0010, 16'h0);
    k = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge CLK); #1;
      chk("cont_single_ack", 32'(a_p0_ack & a_p1_ack), 0);
      if (a_p0_ack || a_p1_ack) begin
        chk($sformatf("cont_ack%0d_cycle", k), 32'(n), 32'(3 * (k + 1)));
        chk($sformatf("cont_ack%0d_port", k), 32'(a_p1_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
        if (a_p1_ack) chk("cont_p1_rdata", 32'(a_p1_rdata), 32'h0000BEEF);
        else          chk("cont_p0_rdata", 32'(a_p0_rdata), 32'h00005A5A);
        k++;
        if (k == 6) begin
          drive_a(0, 0, 0, 0, 0);
          drive_a(1, 0, 0, 0, 0);
          break;
        end
      end
    end
    drive_a(0, 0, 0, 0, 0);
    drive_a(1, 0, 0, 0, 0);
    chk("cont_ack_count", 32'(k), 6);
    @(posedge CLK); #1;
    chk("cont_no_extra_grant", 32'(a_busy), 0);
    exp_r0 = 16'h5A5A; exp_r1 = 16'hBEEF;

    // Requester keeps req high through its ack cycle
    drive_a(0, 1, 0, 16'h0010, 16'h0);
    a1 = -1; a2 = -1; b4 = 1'bx;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      if (n == 4) b4 = a_busy;
      if (a_p0_ack) begin
        if (a1 < 0) a1 = n;
        else begin
          a2 = n;
          break;
        end
      end
    end
    drive_a(0, 0, 0, 0, 0);
    chk("held_first_ack", 32'(a1), 3);
    chk("held_no_regrant_in_ack_cycle", 32'(b4), 0);
    chk("held_second_ack", 32'(a2), 7);
    chk("held_rdata", 32'(a_p0_rdata), 32'h0000BEEF);
    exp_r0 = 16'hBEEF;
    @(posedge CLK); #1;

    // Fixed priority: port 1 starves port 0 until it drops req
    b_p0_req = 1'b1;
    b_p1_req = 1'b1;
    c = -1; p1n = 0; p0at = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge CLK); #1;
      chk("fix_single_ack", 32'(b_p0_ack & b_p1_ack), 0);
      if (b_p1_ack) begin
        p1n++;
        if (p1n == 3) begin
          c = n;
          b_p1_req = 1'b0;
        end
      end
      if (b_p0_ack) begin
        p0at = n;
        break;
      end
    end
    b_p0_req = 1'b0;
    b_p1_req = 1'b0;
    chk("fix_p1_served", 32'(p1n), 3);
    chk("fix_p0_after_drop", 32'(p0at), 32'(c + 3));

    // Random phase: seed a 16-word window, then free-running traffic on both ports
    for (int i = 0; i < 16; i++) begin
      val = 16'($urandom);
      xfer_a(i[0], 1'b1, 16'h0040 + 16'(i), val, rd, lat, wcyc, wbus, maddr);
      chk("seed_latency", 32'(lat), 2);
      mem_m[i] = val;
    end
    exp_rd[0] = exp_r0;
    exp_rd[1] = exp_r1;
    act[0] = 0; act[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK); #1;
      chk("rand_single_ack", 32'(a_p0_ack & a_p1_ack), 0);
      if (a_mem_w)
        chk("rand_write_bus", 32'((act[0] && r_we[0] && a_bus == r_wd[0]) ||
                                  (act[1] && r_we[1] && a_bus == r_wd[1])), 1);
      for (int p = 0; p < 2; p++) begin
        if (p == 1 ? a_p1_ack : a_p0_ack) begin
          chk("rand_ack_expected", 32'(act[p]), 1);
          if (act[p]) begin
            if (r_we[p]) mem_m[r_addr[p][3:0]] = r_wd[p];
            else         exp_rd[p] = mem_m[r_addr[p][3:0]];
          end
          act[p] = 0;
        end
        chk($sformatf("rand_p%0d_rdata", p), 32'(p == 1 ? a_p1_rdata : a_p0_rdata), 32'(exp_rd[p]));
        if (act[p]) begin
          age[p]++;
          if (age[p] > 8) begin
            chk($sformatf("rand_p%0d_latency", p), 32'(age[p]), 8);
            act[p] = 0;
          end
        end
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          act[p]    = 1;
          r_we[p]   = 1'($urandom_range(0, 1));
          r_addr[p] = 16'h0040 + 16'($urandom_range(0, 15));
          r_wd[p]   = 16'($urandom);
          age[p]    = 0;
        end
        drive_a(p[0], act[p], r_we[p], r_addr[p], r_wd[p]);
      end
    end
    drive_a(0, 0, 0, 0, 0);
    drive_a(1, 0, 0, 0, 0);
    repeat (6) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
